// File: rtl/key_debounce_pulse.sv
// ---------------------------------------------------------------------------
// key_debounce_pulse
//   Cleans a raw active-low pushbutton and produces a one-cycle pulse for each
//   accepted press. Its o_pulse drives the T/enable input of the downstream
//   8-bit hex counter, so that counter steps exactly once per physical press.
//   It also provides a debounced level and a one-cycle release pulse.
//
// Optional feature macro: KEY_DEBOUNCE_AUTO_REPEAT_EN
//   When defined, holding the key repeats o_pulse: the first repeat comes
//   REPEAT_DELAY cycles after acceptance, then one every REPEAT_PERIOD cycles.
//   When undefined there is no repeat logic: one pulse per accepted press.
//
// Ports:
//   clk             in   system clock (CLOCK_50)
//   rst             in   asynchronous reset, active low
//   i_key_n         in   raw pushbutton, 0 = pressed (asynchronous, bouncy)
//   o_pulse         out  one-cycle high per accepted press (and per repeat)
//   o_pressed       out  debounced level, 1 = pressed
//   o_release_pulse out  one-cycle high per accepted release
// ---------------------------------------------------------------------------
module key_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_pulse,
    output logic o_pressed,
    output logic o_release_pulse
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debounce_pulse: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 2) begin : g_bad_delay
        $error("key_debounce_pulse: REPEAT_DELAY must be >= 2");
    end
    if (REPEAT_PERIOD < 2) begin : g_bad_period
        $error("key_debounce_pulse: REPEAT_PERIOD must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    state_t        r_state, w_state_nx;
    logic          r_s1, r_s2;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_pulse, r_pressed, r_release_pulse;
    logic          w_pulse_nx, w_pressed_nx, w_release_nx;
    logic          w_accept;

    // Two-flop synchronizer; resets to the released level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_key_n;
            r_s2 <= r_s1;
        end
    end

    // Next-state logic. The stability counter is cleared on every state
    // change and only counts in the two ARM states, so it tops out at
    // CNT_MAX and never wraps.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_accept     = 1'b0;
        w_release_nx = 1'b0;
        w_pressed_nx = r_pressed;
        case (r_state)
            IDLE: begin
                if (!r_s2) begin
                    w_state_nx = ARM_PRESS;
                    w_cnt_nx   = '0;
                end
            end
            ARM_PRESS: begin
                if (r_s2) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nx   = HELD;
                    w_cnt_nx     = '0;
                    w_accept     = 1'b1;
                    w_pressed_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            HELD: begin
                if (r_s2) begin
                    w_state_nx = ARM_RELEASE;
                    w_cnt_nx   = '0;
                end
            end
            ARM_RELEASE: begin
                // A low blip while releasing is bounce: back to HELD, level kept.
                if (!r_s2) begin
                    w_state_nx = HELD;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nx   = IDLE;
                    w_cnt_nx     = '0;
                    w_release_nx = 1'b1;
                    w_pressed_nx = 1'b0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);
    localparam logic [RW-1:0] REP_DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rep_cnt, w_rep_cnt_nx;
    logic          r_rep_ph, w_rep_ph_nx;   // 0: waiting first delay, 1: periodic
    logic          w_rep_hit;
    logic [RW-1:0] w_rep_lim;

    assign w_rep_lim = r_rep_ph ? REP_PER_LAST : REP_DLY_LAST;

    // The counter restarts at each terminal count rather than using a
    // modulo, and simply holds while in ARM_RELEASE.
    always_comb begin
        w_rep_cnt_nx = r_rep_cnt;
        w_rep_ph_nx  = r_rep_ph;
        w_rep_hit    = 1'b0;
        if (r_state == IDLE || w_accept) begin
            w_rep_cnt_nx = '0;
            w_rep_ph_nx  = 1'b0;
        end else if (r_state == HELD && !r_s2) begin
            if (r_rep_cnt == w_rep_lim) begin
                w_rep_hit    = 1'b1;
                w_rep_cnt_nx = '0;
                w_rep_ph_nx  = 1'b1;
            end else begin
                w_rep_cnt_nx = r_rep_cnt + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_cnt <= '0;
            r_rep_ph  <= 1'b0;
        end else begin
            r_rep_cnt <= w_rep_cnt_nx;
            r_rep_ph  <= w_rep_ph_nx;
        end
    end

    assign w_pulse_nx = w_accept | w_rep_hit;
`else
    assign w_pulse_nx = w_accept;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_pulse         <= 1'b0;
            r_pressed       <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_cnt           <= w_cnt_nx;
            r_pulse         <= w_pulse_nx;
            r_pressed       <= w_pressed_nx;
            r_release_pulse <= w_release_nx;
        end
    end

    assign o_pulse         = r_pulse;
    assign o_pressed       = r_pressed;
    assign o_release_pulse = r_release_pulse;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_pulse
//   Directed bench for key_debounce_pulse with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=3. Inputs change 1 ns after a rising edge;
//   outputs are checked at that same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_key_debounce_pulse;

    logic clk;
    logic rst;
    logic key_n;
    logic pulse, pressed, release_pulse;

    int total = 0;
    int bad   = 0;

    // Monitors, sampled on the falling edge.
    int   pulse_cnt = 0;
    int   rel_cnt   = 0;
    int   viol      = 0;
    logic prev_pulse = 1'b0;

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_key_n        (key_n),
        .o_pulse        (pulse),
        .o_pressed      (pressed),
        .o_release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pulse) pulse_cnt++;
        if (release_pulse) rel_cnt++;
        if (pulse && release_pulse) viol++;
        if (pulse && prev_pulse) viol++;
        prev_pulse = pulse;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int          base;
        logic [7:0]  hex;
        logic [24:0] mask;
        logic [24:0] exp_mask;

        key_n = 1'b1;
        rst   = 1'b0;

        // ---- Reset ----
        step(2);
        chk("rst_pulse", pulse, 0);
        chk("rst_pressed", pressed, 0);
        chk("rst_release", release_pulse, 0);
        rst = 1'b1;
        step(3);

        // ---- Clean press: key low sampled at edge k ----
        key_n = 1'b0;
        step(6);                                  // after edge k+5
        chk("clean_pre_pulse", pulse, 0);
        chk("clean_pre_pressed", pressed, 0);
        step(1);                                  // after edge k+6
        chk("clean_pulse", pulse, 1);
        chk("clean_pressed", pressed, 1);
        step(1);
        chk("clean_pulse_one", pulse, 0);
        chk("clean_pressed_hold", pressed, 1);
        step(4);

        // ---- Bounce on release: high 2, low 1, high steady ----
        base  = rel_cnt;
        key_n = 1'b1;
        step(2);
        key_n = 1'b0;
        step(1);
        key_n = 1'b1;                             // steady high sampled at edge r
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("relb_pressed", {31'd0, pressed}, 1);
            chk("relb_no_rel", {31'd0, release_pulse}, 0);
        end
        step(1);                                  // after edge r+6
        chk("relb_rel", release_pulse, 1);
        chk("relb_pressed_off", pressed, 0);
        step(1);
        chk("relb_rel_one", release_pulse, 0);
        step(3);
        chk("relb_rel_cnt", rel_cnt - base, 1);

        // ---- Bounce on press: low 3, high 1, low 2, high 1, low steady ----
        base  = pulse_cnt;
        key_n = 1'b0; step(3);
        key_n = 1'b1; step(1);
        key_n = 1'b0; step(2);
        key_n = 1'b1; step(1);
        key_n = 1'b0;                             // steady low sampled at edge b
        step(6);                                  // after edge b+5
        chk("pressb_no_pulse", pulse_cnt - base, 0);
        chk("pressb_not_pressed", pressed, 0);
        step(1);                                  // after edge b+6
        chk("pressb_pulse", pulse, 1);
        step(3);
        chk("pressb_pulse_cnt", pulse_cnt - base, 1);
        key_n = 1'b1;
        step(10);
        chk("pressb_released", pressed, 0);

        // ---- Reset in ARM_PRESS with cnt=2 ----
        key_n = 1'b0;
        step(5);                                  // after edge k+4: ARM_PRESS, cnt=2
        rst = 1'b0;
        #1;
        chk("rstmid_pulse", pulse, 0);
        chk("rstmid_pressed", pressed, 0);
        chk("rstmid_release", release_pulse, 0);
        step(2);
        rst = 1'b1;                               // key still low; next edge is first sample
        step(6);
        chk("rstmid_pre_pulse", pulse, 0);
        step(1);
        chk("rstmid_pulse_after", pulse, 1);
        chk("rstmid_pressed_after", pressed, 1);

        // ---- Reset while HELD drops the level at once ----
        step(2);
        rst = 1'b0;
        #1;
        chk("rsthld_pressed", pressed, 0);
        key_n = 1'b1;
        step(2);
        rst = 1'b1;
        step(3);

        // ---- Ten presses into the downstream 8-bit counter ----
        base = pulse_cnt;
        for (int p = 0; p < 10; p++) begin
            key_n = 1'b0;
            step(12);
            key_n = 1'b1;
            step(12);
        end
        hex = 8'(pulse_cnt - base);
        chk("cnt10_value", hex, 8'h0A);
        chk("cnt10_hex1", hex[7:4], 4'h0);
        chk("cnt10_hex0", hex[3:0], 4'hA);
        chk("cnt10_released", pressed, 0);

        // ---- Hold 25 cycles after acceptance ----
        key_n = 1'b0;
        step(7);                                  // acceptance edge A
        mask    = '0;
        mask[0] = pulse;
        for (int j = 1; j < 25; j++) begin
            step(1);
            mask[j] = pulse;
        end
        exp_mask    = '0;
        exp_mask[0] = 1'b1;
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
        exp_mask[10] = 1'b1;
        exp_mask[13] = 1'b1;
        exp_mask[16] = 1'b1;
        exp_mask[19] = 1'b1;
        exp_mask[22] = 1'b1;
`endif
        chk("repeat_mask", mask, exp_mask);
        chk("repeat_pressed", pressed, 1);
        key_n = 1'b1;
        step(10);
        chk("repeat_released", pressed, 0);

        // ---- Exclusion checks over the whole run ----
        chk("exclusion_viol", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_debounce_pulse.md
Name: key_debounce_pulse

Overview:
- Cleans a raw active-low DE1 pushbutton (KEY) and emits a single-cycle pulse per accepted press.
- Sits directly upstream of the 8-bit T-flip-flop hex counter. Its `pulse` output drives that counter's T/enable input, so the counter steps exactly once per physical press on the 50 MHz system clock, not on a bouncing key edge.
- Also provides a debounced level and a release pulse for other front-panel logic.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a press or release (10 ms at 50 MHz); legal range ≥2.
- REPEAT_DELAY, 25000000, cycles held before the first auto-repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock (CLOCK_50)
- rst  input  1  reset, asynchronous, active-low
- key_n  input  1  raw pushbutton, 0 = pressed, asynchronous, bouncy
- pulse  output  1  one-cycle high on each accepted press (and on each repeat)
- pressed  output  1  debounced level, 1 = pressed
- release_pulse  output  1  one-cycle high on each accepted release

Behaviour:
- Reset: asserting rst takes effect immediately, including mid-operation.
  - Sync stages are set to 1 (released).
  - State goes to IDLE; all counters are set to 0.
  - pulse=0, pressed=0, release_pulse=0.
- Synchronizer: key_n passes through two flops, s1 then s2. Only s2 is used downstream.
- Stability counter: width $clog2(DEBOUNCE_CYCLES).
  - Cleared on every state entry.
  - Increments each cycle while s2 matches the candidate level.
- State machine (all outputs registered):
  - IDLE: s2=0 → ARM_PRESS, cnt=0.
  - ARM_PRESS: s2=1 → IDLE (glitch rejected, no output). s2=0 and cnt==DEBOUNCE_CYCLES-1 → HELD, with pulse=1 for one cycle and pressed=1. Otherwise cnt++.
  - HELD: s2=1 → ARM_RELEASE, cnt=0.
  - ARM_RELEASE: s2=0 → HELD (bounce on release, no pulse, pressed stays 1). s2=1 and cnt==DEBOUNCE_CYCLES-1 → IDLE, with release_pulse=1 for one cycle and pressed=0. Otherwise cnt++.
- Latency: let edge k be the first clock edge that samples key_n=0 into s1, with key_n stable low thereafter. Then pulse is high for exactly the cycle after edge k+DEBOUNCE_CYCLES+2. Release is symmetric for release_pulse.
- Glitch rejection: any low excursion shorter than DEBOUNCE_CYCLES cycles (at s2) produces no pulse, however many times it repeats.
- Mutual exclusion:
  - pulse and release_pulse are never high in the same cycle.
  - pulse is never high on two consecutive cycles.
- Counter width: the counter never exceeds DEBOUNCE_CYCLES-1 and has no wrap-around path.

Optional Feature:
- Macro: KEY_DEBOUNCE_AUTO_REPEAT_EN.
- Defined:
  - A repeat counter is cleared on the IDLE→ARM_PRESS→HELD entry and increments each cycle in HELD.
  - When it reaches REPEAT_DELAY-1, pulse=1 for one cycle; thereafter pulse=1 every REPEAT_PERIOD cycles while in HELD.
  - The repeat counter freezes in ARM_RELEASE and resumes if the FSM returns to HELD.
  - It clears on IDLE.
  - release_pulse behaviour is unchanged.
- Undefined: no repeat logic exists; exactly one pulse per accepted press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press: rst low 2 cycles then high; key_n 1→0 sampled at edge k and held → pulse=1 only in the cycle after edge k+6, pressed=1 from the same edge.
- Bounce on press: key_n low 3 cycles, high 1, low 2, high 1, then low steady → no pulse during the bounces; exactly one pulse 6 edges after the final low begins; pulse count = 1.
- Bounce on release: after press accepted, key_n high 2, low 1, high steady → pressed stays 1 through the bounce; release_pulse=1 once, 6 edges after steady high; pressed=0 from the same edge.
- Reset mid-operation: rst driven low while in ARM_PRESS with cnt=2, key_n still low → outputs 0 immediately; after rst release with key_n held low, pulse arrives 6 edges after the first post-reset sample.
- Ten clean presses feeding the downstream 8-bit counter → counter reads 0x0A, HEX1=0, HEX0=A.
- AUTO_REPEAT_EN defined, key held 25 cycles after acceptance → pulses at acceptance, +10, +13, +16, +19, +22 (six total); with the macro undefined → one pulse.
